multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Multi-cycle sequencer for the MIPS datapath. It replaces single-cycle decode with an FSM that drives the shared ALU, register file and a unified instruction/data memory across several cycles per instruction. It waits on a memory-ready handshake and traps on unsupported opcodes. It sits beside the register file, ALU and ALU_Control; its ALUOp output feeds ALU_Control unchanged.

Parameters:
CNT_W, 32, width of retired-instruction counter (used only with MC_PERF_CNT_EN)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  instruction[31:26] from the instruction register (IR)
mem_ready  in  1  memory completes the current read/write this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU zero (beq)
IorD  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  load IR from memory data
MemToReg  out  1  write-back source: 1 = MDR, 0 = ALUOut
RegDst  out  1  1 = rd, 0 = rt
RegWrite  out  1  register file write enable
ALUSrcA  out  1  0 = PC, 1 = rd1
ALUSrcB  out  2  00 = rd2, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
ALUOp  out  2  00 = add, 01 = sub, 10 = use funct
PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
trap  out  1  sticky illegal-opcode indication

Behaviour:
- Reset: rst_n low forces state = FETCH immediately and drives every output to 0, including trap. On rst_n release, FETCH outputs apply from the next edge.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000. Any other opcode is illegal.
- States and outputs. Outputs are Moore; outputs marked "qualified" are ANDed with mem_ready.
  - FETCH: MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite qualified. Stay until mem_ready=1, then go to DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode: lw/sw -> MEM_ADDR, R -> EXEC, beq -> BRANCH, j -> JUMP, addi -> ADDI_EXEC, illegal -> TRAP.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEM_READ if lw, MEM_WRITE if sw.
  - MEM_READ: MemRead, IorD=1. Stay until mem_ready, then go to MEM_WB.
  - MEM_WB: RegWrite, RegDst=0, MemToReg=1. Go to FETCH.
  - MEM_WRITE: MemWrite, IorD=1. Stay until mem_ready, then go to FETCH.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to R_WB.
  - R_WB: RegWrite, RegDst=1, MemToReg=0. Go to FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01. Go to FETCH.
  - JUMP: PCWrite, PCSource=10. Go to FETCH.
  - ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to ADDI_WB.
  - ADDI_WB: RegWrite, RegDst=0, MemToReg=0. Go to FETCH.
  - TRAP: trap=1; all other outputs 0. Absorbing state; exit only via rst_n.
- Latency with mem_ready tied high: beq/j 3 cycles, R/sw/addi 4, lw 5. Each cycle mem_ready is low in a wait state adds exactly one cycle.
- MemRead/MemWrite are held stable while waiting. mem_ready outside FETCH/MEM_READ/MEM_WRITE is ignored.
- opcode is sampled only in DECODE and MEM_ADDR; it is stable because IRWrite is low there.
- A reset asserted mid-instruction (any state, including a wait) aborts the instruction; no write strobe is issued after the asserting edge.
- Unused state encodings recover to FETCH.

Optional Feature:
MC_PERF_CNT_EN
- Defined: adds output retired [CNT_W-1:0], reset 0. It increments on every transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP or ADDI_WB. It wraps modulo 2^CNT_W and does not increment in TRAP.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package mips_pkg holds:
  - state enum mc_state_t
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI
  - ALUOp encodings ALUOP_ADD/SUB/FUNCT
  - ALUSrcB and PCSource encodings
- No sub-module: state register, next-state logic and output decode stay in one module. The perf counter is an inline ifdef block.

Test Plan:
- Reset: hold rst_n=0 mid-clock -> all outputs 0 and trap=0 without waiting for a clock edge. Release -> first cycle MemRead=1, IorD=0, ALUSrcB=01.
- R-type: opcode=000000, mem_ready=1 -> FETCH, DECODE, EXEC (ALUOp=10), R_WB (RegWrite=1, RegDst=1). Back in FETCH at cycle 5; retired=1 with MC_PERF_CNT_EN.
- lw with slow memory: mem_ready low 2 cycles in FETCH and 3 cycles in MEM_READ -> IRWrite pulses once, only on the ready cycle. MEM_WB asserts RegWrite=1, MemToReg=1. Total 10 cycles.
- beq and j: opcode=000100 -> BRANCH drives PCWriteCond=1, ALUOp=01, PCSource=01. opcode=000010 -> JUMP drives PCWrite=1, PCSource=10. Each takes 3 cycles.
- Illegal opcode 111111 -> TRAP after DECODE; trap=1 held for 20 cycles regardless of mem_ready; retired unchanged. rst_n pulse -> FETCH.
- Reset mid-MEM_WRITE with mem_ready=0 -> MemWrite drops asynchronously and the next instruction starts at FETCH.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS sequencer: state encoding, opcodes,
// datapath mux encodings and the per-state control decode.
package mips_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXEC      = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_ADDI_EXEC = 4'd10,
        ST_ADDI_WB   = 4'd11,
        ST_TRAP      = 4'd12
    } mc_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // pc_write_fetch and ir_write are later qualified with mem_ready
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_fetch;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       trap;
    } mc_ctrl_t;

    function automatic mc_ctrl_t mc_decode(input logic [3:0] state);
        mc_ctrl_t c;
        c = '0;
        case (state)
            ST_FETCH: begin
                c.mem_read       = 1'b1;
                c.alu_src_b      = SRCB_FOUR;
                c.alu_op         = ALUOP_ADD;
                c.pc_source      = PCSRC_ALU;
                c.ir_write       = 1'b1;
                c.pc_write_fetch = 1'b1;
            end
            ST_DECODE:    c.alu_src_b = SRCB_IMM_SH2;
            ST_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            ST_MEM_READ: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            ST_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
            end
            ST_ADDI_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            ST_ADDI_WB:   c.reg_write = 1'b1;
            ST_TRAP:      c.trap = 1'b1;
            default:      c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM with memory-ready handshake and illegal-opcode trap.
// Optional retired-instruction counter enabled by defining MC_PERF_CNT_EN.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemToReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       trap
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] retired
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_invalid
        $error("CNT_W must be at least 1");
    end

    logic [3:0] state_r;
    logic [3:0] state_next_s;
    logic       run_r;
    mc_ctrl_t   ctrl_r;

    // Next-state selection; the first edge after reset only arms the FSM in FETCH
    always_comb begin
        state_next_s = ST_FETCH;
        if (!run_r) begin
            state_next_s = ST_FETCH;
        end else begin
            case (state_r)
                ST_FETCH:     state_next_s = mem_ready ? ST_DECODE : ST_FETCH;
                ST_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW: state_next_s = ST_MEM_ADDR;
                        OP_RTYPE:     state_next_s = ST_EXEC;
                        OP_BEQ:       state_next_s = ST_BRANCH;
                        OP_J:         state_next_s = ST_JUMP;
                        OP_ADDI:      state_next_s = ST_ADDI_EXEC;
                        default:      state_next_s = ST_TRAP;
                    endcase
                end
                ST_MEM_ADDR: begin
                    if (opcode == OP_LW) begin
                        state_next_s = ST_MEM_READ;
                    end else if (opcode == OP_SW) begin
                        state_next_s = ST_MEM_WRITE;
                    end else begin
                        state_next_s = ST_FETCH;
                    end
                end
                ST_MEM_READ:  state_next_s = mem_ready ? ST_MEM_WB : ST_MEM_READ;
                ST_MEM_WRITE: state_next_s = mem_ready ? ST_FETCH : ST_MEM_WRITE;
                ST_EXEC:      state_next_s = ST_R_WB;
                ST_ADDI_EXEC: state_next_s = ST_ADDI_WB;
                ST_MEM_WB, ST_R_WB, ST_BRANCH, ST_JUMP, ST_ADDI_WB:
                              state_next_s = ST_FETCH;
                ST_TRAP:      state_next_s = ST_TRAP;
                default:      state_next_s = ST_FETCH;
            endcase
        end
    end

    // State and decoded control registers; reset clears every output immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FETCH;
            run_r   <= 1'b0;
            ctrl_r  <= '0;
        end else begin
            state_r <= state_next_s;
            run_r   <= 1'b1;
            ctrl_r  <= mc_decode(state_next_s);
        end
    end

    assign PCWrite     = ctrl_r.pc_write | (ctrl_r.pc_write_fetch & mem_ready);
    assign IRWrite     = ctrl_r.ir_write & mem_ready;
    assign PCWriteCond = ctrl_r.pc_write_cond;
    assign IorD        = ctrl_r.iord;
    assign MemRead     = ctrl_r.mem_read;
    assign MemWrite    = ctrl_r.mem_write;
    assign MemToReg    = ctrl_r.mem_to_reg;
    assign RegDst      = ctrl_r.reg_dst;
    assign RegWrite    = ctrl_r.reg_write;
    assign ALUSrcA     = ctrl_r.alu_src_a;
    assign ALUSrcB     = ctrl_r.alu_src_b;
    assign ALUOp       = ctrl_r.alu_op;
    assign PCSource    = ctrl_r.pc_source;
    assign trap        = ctrl_r.trap;

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] retired_r;
    logic             retire_s;

    // An instruction retires when a final state hands control back to FETCH
    always_comb begin
        retire_s = 1'b0;
        if (run_r && (state_next_s == ST_FETCH)) begin
            case (state_r)
                ST_MEM_WB, ST_MEM_WRITE, ST_R_WB, ST_BRANCH, ST_JUMP, ST_ADDI_WB:
                         retire_s = 1'b1;
                default: retire_s = 1'b0;
            endcase
        end else begin
            retire_s = 1'b0;
        end
    end

    // Free-running retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_r <= '0;
        end else if (retire_s) begin
            retired_r <= retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            retired_r <= retired_r;
        end
    end

    assign retired = retired_r;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control: a per-opcode phase script
// predicts the control outputs every cycle, with random memory wait states.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       mem_ready = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemToReg, RegDst, RegWrite, ALUSrcA, trap;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
`ifdef MC_PERF_CNT_EN
    logic [31:0] retired;
`endif

    int checks = 0;
    int failures = 0;
    int model_retired = 0;

    localparam int PH_FETCH = 0, PH_DECODE = 1, PH_MEM_ADDR = 2, PH_MEM_READ = 3,
                   PH_MEM_WB = 4, PH_MEM_WRITE = 5, PH_EXEC = 6, PH_R_WB = 7,
                   PH_BRANCH = 8, PH_JUMP = 9, PH_ADDI_EXEC = 10, PH_ADDI_WB = 11,
                   PH_TRAP = 12;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca;
        logic [1:0] srcb, aluop, pcsrc;
        logic       trap;
    } obs_t;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .trap(trap)
`ifdef MC_PERF_CNT_EN
        , .retired(retired)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic string pname(input int ph);
        case (ph)
            PH_FETCH:     return "fetch";
            PH_DECODE:    return "decode";
            PH_MEM_ADDR:  return "mem_addr";
            PH_MEM_READ:  return "mem_read";
            PH_MEM_WB:    return "mem_wb";
            PH_MEM_WRITE: return "mem_write";
            PH_EXEC:      return "exec";
            PH_R_WB:      return "r_wb";
            PH_BRANCH:    return "branch";
            PH_JUMP:      return "jump";
            PH_ADDI_EXEC: return "addi_exec";
            PH_ADDI_WB:   return "addi_wb";
            PH_TRAP:      return "trap";
            default:      return "unknown";
        endcase
    endfunction

    function automatic obs_t expect_of(input int ph, input logic mr);
        obs_t e;
        e = '0;
        case (ph)
            PH_FETCH:     begin e.mrd = 1'b1; e.srcb = 2'b01; e.irw = mr; e.pcw = mr; end
            PH_DECODE:    e.srcb = 2'b11;
            PH_MEM_ADDR:  begin e.srca = 1'b1; e.srcb = 2'b10; end
            PH_MEM_READ:  begin e.mrd = 1'b1; e.iord = 1'b1; end
            PH_MEM_WB:    begin e.rwr = 1'b1; e.m2r = 1'b1; end
            PH_MEM_WRITE: begin e.mwr = 1'b1; e.iord = 1'b1; end
            PH_EXEC:      begin e.srca = 1'b1; e.aluop = 2'b10; end
            PH_R_WB:      begin e.rwr = 1'b1; e.rdst = 1'b1; end
            PH_BRANCH:    begin e.srca = 1'b1; e.aluop = 2'b01; e.pcwc = 1'b1; e.pcsrc = 2'b01; end
            PH_JUMP:      begin e.pcw = 1'b1; e.pcsrc = 2'b10; end
            PH_ADDI_EXEC: begin e.srca = 1'b1; e.srcb = 2'b10; end
            PH_ADDI_WB:   e.rwr = 1'b1;
            PH_TRAP:      e.trap = 1'b1;
            default:      e = '0;
        endcase
        return e;
    endfunction

    function automatic obs_t observed();
        obs_t o;
        o = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
             RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, trap};
        return o;
    endfunction

    function automatic logic [5:0] pick_legal();
        case ($urandom_range(0, 5))
            0:       return 6'b000000;
            1:       return 6'b100011;
            2:       return 6'b101011;
            3:       return 6'b000100;
            4:       return 6'b000010;
            default: return 6'b001000;
        endcase
    endfunction

    function automatic logic [5:0] pick_illegal();
        logic [5:0] op;
        op = 6'b111111;
        for (int i = 0; i < 16; i++) begin
            op = 6'($urandom_range(0, 63));
            if (op != 6'b000000 && op != 6'b100011 && op != 6'b101011 &&
                op != 6'b000100 && op != 6'b000010 && op != 6'b001000) break;
            op = 6'b111111;
        end
        return op;
    endfunction

    task automatic step(input int ph, input logic mr);
        @(negedge clk);
        mem_ready = mr;
        #1;
        chk(pname(ph), 32'(observed()), 32'(expect_of(ph, mr)));
    endtask

    task automatic rand_step(input int ph);
        step(ph, 1'($urandom_range(0, 1)));
    endtask

    // Wait-capable phase: mem_ready low for 'waits' cycles, then high once
    task automatic wait_phase(input int ph, input int waits);
        int w;
        w = (waits < 0) ? int'($urandom_range(0, 2)) : waits;
        for (int k = 0; k <= w; k++) step(ph, k == w);
    endtask

    task automatic run_instr(input logic [5:0] op, input int fwait, input int mwait, input bit abort_write);
        int w;
        opcode = op;
        w = (fwait < 0) ? int'($urandom_range(0, 2)) : fwait;
        for (int k = 0; k <= w; k++) begin
            step(PH_FETCH, k == w);
`ifdef MC_PERF_CNT_EN
            if (k == 0) chk("retired", retired, 32'(model_retired));
`endif
        end
        rand_step(PH_DECODE);
        case (op)
            6'b100011: begin
                rand_step(PH_MEM_ADDR);
                wait_phase(PH_MEM_READ, mwait);
                rand_step(PH_MEM_WB);
                model_retired++;
            end
            6'b101011: begin
                rand_step(PH_MEM_ADDR);
                if (abort_write) begin
                    step(PH_MEM_WRITE, 1'b0);
                    return;
                end
                wait_phase(PH_MEM_WRITE, mwait);
                model_retired++;
            end
            6'b000000: begin rand_step(PH_EXEC); rand_step(PH_R_WB); model_retired++; end
            6'b000100: begin rand_step(PH_BRANCH); model_retired++; end
            6'b000010: begin rand_step(PH_JUMP); model_retired++; end
            6'b001000: begin rand_step(PH_ADDI_EXEC); rand_step(PH_ADDI_WB); model_retired++; end
            default: begin
                for (int k = 0; k < 20; k++) rand_step(PH_TRAP);
`ifdef MC_PERF_CNT_EN
                chk("retired_in_trap", retired, 32'(model_retired));
`endif
            end
        endcase
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_async", 32'(observed()), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_hold", 32'(observed()), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_release", 32'(observed()), 32'd0);
        model_retired = 0;
`ifdef MC_PERF_CNT_EN
        chk("retired_rst", retired, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #3;
        do_reset();
        run_instr(6'b000000, 0, 0, 1'b0);
        run_instr(6'b100011, 2, 3, 1'b0);
        run_instr(6'b000100, 0, 0, 1'b0);
        run_instr(6'b000010, 0, 0, 1'b0);
        run_instr(6'b001000, 0, 0, 1'b0);
        run_instr(6'b101011, 1, 2, 1'b0);
        repeat (60) run_instr(pick_legal(), -1, -1, 1'b0);
        run_instr(6'b101011, 0, 0, 1'b1);
        @(negedge clk);
        #1;
        chk("mw_held", 32'(MemWrite), 32'd1);
        do_reset();
        run_instr(6'b000000, -1, -1, 1'b0);
        run_instr(6'b111111, 0, 0, 1'b0);
        do_reset();
        repeat (10) run_instr(pick_legal(), -1, -1, 1'b0);
        run_instr(pick_illegal(), -1, 0, 1'b0);
        do_reset();
        run_instr(6'b100011, -1, -1, 1'b0);
        run_instr(6'b000000, 0, 0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
